// File: rtl/bso_count_fsm.sv
// bso_count_fsm
// Ball/strike/out counter for the scoreboard. It takes the one-cycle press
// pulses from the button pulse generators and keeps the ball, strike, out,
// half-inning and inning counts using baseball counting rules. At each
// three-out side change the display is frozen for HOLD_CYC cycles. The
// machine stops at game end and stays there until reset.
//
// Parameters:
//   HOLD_CYC   - cycles the three-out display is held (>= 1)
//   MAX_INNING - last inning; the game ends on the third out of its bottom half
//
// Ports:
//   iCLK, iRST         - clock and synchronous active-high reset
//   iBALL .. iHIT      - one-cycle event pulses
//   oBALL, oSTRIKE     - current count
//   oOUT               - outs; 3 is shown only during the hold and after game end
//   oINNING, oTOP      - inning number and half (1 = top)
//   oWALK, oKOUT       - one-cycle pulses on a walk or a strikeout
//   oOVER              - game has ended
module bso_count_fsm #(
  parameter int HOLD_CYC   = 4,
  parameter int MAX_INNING = 9
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iBALL,
  input  logic       iSTRIKE,
  input  logic       iFOUL,
  input  logic       iOUT,
  input  logic       iHIT,
  output logic [1:0] oBALL,
  output logic [1:0] oSTRIKE,
  output logic [1:0] oOUT,
  output logic [3:0] oINNING,
  output logic       oTOP,
  output logic       oWALK,
  output logic       oKOUT,
  output logic       oOVER
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int              HW           = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0]   HOLD_LAST    = HW'(HOLD_CYC - 1);
  localparam logic [3:0]      LAST_INNING  = 4'(MAX_INNING);

  state_e        state_q, state_d;
  logic [1:0]    ball_q, ball_d;
  logic [1:0]    strike_q, strike_d;
  logic [1:0]    out_q, out_d;
  logic [3:0]    inning_q, inning_d;
  logic          top_q, top_d;
  logic          walk_q, walk_d;
  logic          kout_q, kout_d;
  logic          over_q, over_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          take_out;

  // Next-state logic. Only one event is honoured per cycle in PLAY; the
  // if/else chain encodes the out > hit > strike > foul > ball priority and
  // simply drops the losers. A strikeout raises take_out so that it shares
  // the out bookkeeping with a plain out.
  always_comb begin
    state_d    = state_q;
    ball_d     = ball_q;
    strike_d   = strike_q;
    out_d      = out_q;
    inning_d   = inning_q;
    top_d      = top_q;
    walk_d     = 1'b0;
    kout_d     = 1'b0;
    over_d     = over_q;
    hold_cnt_d = hold_cnt_q;
    take_out   = 1'b0;

    case (state_q)
      PLAY: begin
        if (iOUT) begin
          take_out = 1'b1;
        end else if (iHIT) begin
          ball_d   = 2'd0;
          strike_d = 2'd0;
        end else if (iSTRIKE) begin
          if (strike_q == 2'd2) begin
            kout_d   = 1'b1;
            take_out = 1'b1;
          end else begin
            strike_d = strike_q + 2'd1;
          end
        end else if (iFOUL) begin
          // A foul never produces the third strike.
          if (strike_q != 2'd2) begin
            strike_d = strike_q + 2'd1;
          end
        end else if (iBALL) begin
          if (ball_q == 2'd3) begin
            ball_d   = 2'd0;
            strike_d = 2'd0;
            walk_d   = 1'b1;
          end else begin
            ball_d = ball_q + 2'd1;
          end
        end
      end

      HOLD: begin
        ball_d   = 2'd0;
        strike_d = 2'd0;
        if (hold_cnt_q == HOLD_LAST) begin
          if (top_q) begin
            top_d   = 1'b0;
            out_d   = 2'd0;
            state_d = PLAY;
          end else if (inning_q < LAST_INNING) begin
            top_d    = 1'b1;
            inning_d = inning_q + 4'd1;
            out_d    = 2'd0;
            state_d  = PLAY;
          end else begin
            // Third out of the last bottom half: keep 0/0/3 on display.
            over_d  = 1'b1;
            state_d = OVER;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      OVER: begin
      end

      default: begin
        state_d = PLAY;
      end
    endcase

    // Out bookkeeping shared by iOUT and the strikeout path.
    if (take_out) begin
      ball_d   = 2'd0;
      strike_d = 2'd0;
      if (out_q == 2'd2) begin
        out_d      = 2'd3;
        hold_cnt_d = '0;
        state_d    = HOLD;
      end else begin
        out_d = out_q + 2'd1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= PLAY;
      ball_q     <= 2'd0;
      strike_q   <= 2'd0;
      out_q      <= 2'd0;
      inning_q   <= 4'd1;
      top_q      <= 1'b1;
      walk_q     <= 1'b0;
      kout_q     <= 1'b0;
      over_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ball_q     <= ball_d;
      strike_q   <= strike_d;
      out_q      <= out_d;
      inning_q   <= inning_d;
      top_q      <= top_d;
      walk_q     <= walk_d;
      kout_q     <= kout_d;
      over_q     <= over_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign oBALL   = ball_q;
  assign oSTRIKE = strike_q;
  assign oOUT    = out_q;
  assign oINNING = inning_q;
  assign oTOP    = top_q;
  assign oWALK   = walk_q;
  assign oKOUT   = kout_q;
  assign oOVER   = over_q;

endmodule

// File: tb/tb_bso_count_fsm.sv
// tb_bso_count_fsm
// Drives the scoreboard count FSM with directed scenarios and random pulse
// traffic, and compares every output after every edge against a reference
// model of the game rules kept in this module.
module tb_bso_count_fsm;

  localparam int TB_HOLD = 4;
  localparam int TB_MAX  = 2;

  localparam int M_PLAY = 0;
  localparam int M_HOLD = 1;
  localparam int M_OVER = 2;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iBALL = 1'b0;
  logic       iSTRIKE = 1'b0;
  logic       iFOUL = 1'b0;
  logic       iOUT = 1'b0;
  logic       iHIT = 1'b0;
  logic [1:0] oBALL;
  logic [1:0] oSTRIKE;
  logic [1:0] oOUT;
  logic [3:0] oINNING;
  logic       oTOP;
  logic       oWALK;
  logic       oKOUT;
  logic       oOVER;

  int checks   = 0;
  int failures = 0;
  int stepNo   = 0;

  int mMode;
  int mBalls;
  int mStrikes;
  int mOuts;
  int mInning;
  int mTop;
  int mWalk;
  int mKout;
  int mOver;
  int mHoldLeft;

  bso_count_fsm #(
    .HOLD_CYC  (TB_HOLD),
    .MAX_INNING(TB_MAX)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iBALL  (iBALL),
    .iSTRIKE(iSTRIKE),
    .iFOUL  (iFOUL),
    .iOUT   (iOUT),
    .iHIT   (iHIT),
    .oBALL  (oBALL),
    .oSTRIKE(oSTRIKE),
    .oOUT   (oOUT),
    .oINNING(oINNING),
    .oTOP   (oTOP),
    .oWALK  (oWALK),
    .oKOUT  (oKOUT),
    .oOVER  (oOVER)
  );

  // Free-running 10-unit clock.
  always #5 iCLK = ~iCLK;

  // Records an out in the model: clears the count and starts the hold on
  // the third out, counting down the cycles the display stays frozen.
  task automatic modelOut();
    mBalls   = 0;
    mStrikes = 0;
    mOuts    = mOuts + 1;
    if (mOuts == 3) begin
      mMode     = M_HOLD;
      mHoldLeft = TB_HOLD;
    end
  endtask

  // Advances the game model by one clock edge given the sampled inputs.
  task automatic modelStep(input logic r, input logic b, input logic s,
                           input logic f, input logic o, input logic h);
    mWalk = 0;
    mKout = 0;
    if (r) begin
      mMode = M_PLAY; mBalls = 0; mStrikes = 0; mOuts = 0;
      mInning = 1; mTop = 1; mOver = 0; mHoldLeft = 0;
    end else if (mMode == M_HOLD) begin
      mHoldLeft = mHoldLeft - 1;
      if (mHoldLeft == 0) begin
        if (mTop == 1) begin
          mTop = 0; mOuts = 0; mMode = M_PLAY;
        end else if (mInning < TB_MAX) begin
          mTop = 1; mInning = mInning + 1; mOuts = 0; mMode = M_PLAY;
        end else begin
          mOver = 1; mMode = M_OVER;
        end
      end
    end else if (mMode == M_PLAY) begin
      if (o) begin
        modelOut();
      end else if (h) begin
        mBalls = 0; mStrikes = 0;
      end else if (s) begin
        if (mStrikes == 2) begin
          mKout = 1;
          modelOut();
        end else begin
          mStrikes = mStrikes + 1;
        end
      end else if (f) begin
        if (mStrikes < 2) mStrikes = mStrikes + 1;
      end else if (b) begin
        if (mBalls == 3) begin
          mWalk = 1; mBalls = 0; mStrikes = 0;
        end else begin
          mBalls = mBalls + 1;
        end
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [3:0] observed,
                          input logic [3:0] expected);
    checks = checks + 1;
    assert (observed === expected)
      else begin
        failures = failures + 1;
        $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d",
               tag, stepNo, observed, expected);
      end
  endtask

  // Compares every DUT output against the model.
  task automatic checkOutput();
    checkOne("ball",   {2'b00, oBALL},   4'(mBalls));
    checkOne("strike", {2'b00, oSTRIKE}, 4'(mStrikes));
    checkOne("out",    {2'b00, oOUT},    4'(mOuts));
    checkOne("inning", oINNING,          4'(mInning));
    checkOne("top",    {3'b000, oTOP},   4'(mTop));
    checkOne("walk",   {3'b000, oWALK},  4'(mWalk));
    checkOne("kout",   {3'b000, oKOUT},  4'(mKout));
    checkOne("over",   {3'b000, oOVER},  4'(mOver));
  endtask

  // Holds the given inputs over one rising edge, then checks 1 unit later.
  task automatic applyStimulus(input logic r, input logic b, input logic s,
                               input logic f, input logic o, input logic h);
    iRST = r; iBALL = b; iSTRIKE = s; iFOUL = f; iOUT = o; iHIT = h;
    @(posedge iCLK);
    modelStep(r, b, s, f, o, h);
    #1;
    stepNo = stepNo + 1;
    checkOutput();
  endtask

  task automatic randomPulses();
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
  endtask

  // Three outs followed by the hold period with random inputs that must be ignored.
  task automatic playHalf();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOne("holdOut3", {2'b00, oOUT}, 4'd3);
    for (int i = 0; i < TB_HOLD; i++) randomPulses();
  endtask

  initial begin
    mMode = M_PLAY; mBalls = 0; mStrikes = 0; mOuts = 0; mInning = 1;
    mTop = 1; mWalk = 0; mKout = 0; mOver = 0; mHoldLeft = 0;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOne("rstInning", oINNING, 4'd1);

    // Four balls back to back: 1,2,3 then walk.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOne("walkPulse", {3'b000, oWALK}, 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOne("walkOneCycle", {3'b000, oWALK}, 4'd0);

    // Two strikes, three fouls, strikeout.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOne("foulAtTwo", {2'b00, oSTRIKE}, 4'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOne("koutPulse", {3'b000, oKOUT}, 4'd1);
    checkOne("koutOut", {2'b00, oOUT}, 4'd1);

    // Priority: 1-1 count then out+ball+strike together; then foul+ball.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOne("prioOut", {2'b00, oOUT}, 4'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOne("prioFoul", {2'b00, oSTRIKE}, 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Side changes through game end.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    playHalf();
    checkOne("side1Top", {3'b000, oTOP}, 4'd0);
    checkOne("side1Out", {2'b00, oOUT}, 4'd0);
    playHalf();
    checkOne("side2Inning", oINNING, 4'd2);
    playHalf();
    playHalf();
    checkOne("gameOver", {3'b000, oOVER}, 4'd1);
    for (int i = 0; i < 8; i++) randomPulses();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOne("overReset", {3'b000, oOVER}, 4'd0);

    // Reset on the second hold cycle cancels the side change.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TB_HOLD + 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOne("holdRstTop", {3'b000, oTOP}, 4'd1);

    // Random traffic with sparse pulses and rare resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 249) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
